// File: rtl/octal_mon_pkg.sv
// Shared widths, thresholds and FSM encoding for the octal decode monitor.
package octal_mon_pkg;

  localparam int unsigned DecW        = 8;
  localparam int unsigned IdxW        = 3;
  localparam int unsigned CntW        = 16;
  // Counts below this index are expected to have the carry output high.
  localparam int unsigned CarryThresh = 4;

  typedef enum logic [1:0] {
    StAcquire = 2'd0,
    StLock    = 2'd1,
    StFault   = 2'd2
  } state_e;

endpackage

// File: rtl/onehot_encoder.sv
// Combinational 1-of-8 to binary encoder with a legality flag (exactly one bit set).
module onehot_encoder
  import octal_mon_pkg::*;
(
  input  logic [DecW-1:0] dec_i,
  output logic [IdxW-1:0] idx_o,
  output logic            legal_o
);

  localparam int unsigned OnesW = $clog2(DecW + 1);

  logic [OnesW-1:0] ones;

  // Count set bits and remember the position of a set bit.
  always_comb begin
    idx_o = '0;
    ones  = '0;
    for (int unsigned i = 0; i < DecW; i++) begin
      if (dec_i[i]) begin
        idx_o = IdxW'(i);
        ones  = ones + OnesW'(1);
      end
    end
    legal_o = (ones == OnesW'(1));
  end

endmodule

// File: rtl/octal_decode_monitor.sv
// Monitors the decoded outputs of an octal Johnson counter: tracks the count index,
// flags sequence/one-hot/carry errors and counts full 7->0 cycles.
module octal_decode_monitor
  import octal_mon_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  input  logic [DecW-1:0] decoded_i,
  input  logic            carry_i,
  input  logic            clear_err_i,
  output logic [IdxW-1:0] index_o,
  output logic            index_valid_o,
  output logic            step_o,
  output logic            wrap_o,
  output logic [CntW-1:0] cycle_count_o,
  output logic            err_onehot_o,
  output logic            err_seq_o,
  output logic            err_carry_o
);

  // Stage 1 input registers.
  logic [DecW-1:0] dec_s1_q;
  logic            carry_s1_q, en_s1_q;

  // Stage 2 state and registered outputs.
  state_e          state_q, state_d;
  logic [IdxW-1:0] index_q, index_d;
  logic            step_q, step_d, wrap_q, wrap_d;
  logic [CntW-1:0] cycle_count_q, cycle_count_d;
  logic            err_onehot_q, err_onehot_d;
  logic            err_seq_q, err_seq_d;
  logic            err_carry_q, err_carry_d;

  logic [IdxW-1:0] enc_idx, idx_next;
  logic            enc_legal, carry_exp;
  logic            new_onehot, new_seq, new_carry;

  onehot_encoder u_enc (
    .dec_i   (dec_s1_q),
    .idx_o   (enc_idx),
    .legal_o (enc_legal)
  );

  assign idx_next  = index_q + IdxW'(1);
  assign carry_exp = (32'(enc_idx) < CarryThresh);

  // Capture raw inputs; evaluation always works on the previous cycle's sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_s1_q   <= '0;
      carry_s1_q <= 1'b0;
      en_s1_q    <= 1'b0;
    end else begin
      dec_s1_q   <= decoded_i;
      carry_s1_q <= carry_i;
      en_s1_q    <= enable_i;
    end
  end

  // Next-state: FSM transitions, index tracking, pulses, cycle count and sticky errors.
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    step_d        = 1'b0;
    wrap_d        = 1'b0;
    cycle_count_d = cycle_count_q;
    new_onehot    = 1'b0;
    new_seq       = 1'b0;
    new_carry     = 1'b0;

    if (en_s1_q) begin
      if (enc_legal) begin
        new_carry = (carry_s1_q != carry_exp);
        case (state_q)
          StLock: begin
            if (enc_idx == idx_next) begin
              step_d  = 1'b1;
              index_d = enc_idx;
              if (index_q == IdxW'(DecW - 1)) begin
                wrap_d        = 1'b1;
                cycle_count_d = cycle_count_q + CntW'(1);
              end
            end else if (enc_idx != index_q) begin
              new_seq = 1'b1;
              index_d = enc_idx;
            end
          end
          default: begin
            // Acquire or fault: resynchronise on any legal sample without pulsing.
            state_d = StLock;
            index_d = enc_idx;
          end
        endcase
      end else begin
        new_onehot = 1'b1;
        if (state_q == StLock) state_d = StFault;
      end
    end

    // A newly detected error overrides a coincident clear.
    err_onehot_d = (clear_err_i ? 1'b0 : err_onehot_q) | new_onehot;
    err_seq_d    = (clear_err_i ? 1'b0 : err_seq_q)    | new_seq;
    err_carry_d  = (clear_err_i ? 1'b0 : err_carry_q)  | new_carry;
  end

  // Stage 2 state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StAcquire;
      index_q       <= '0;
      step_q        <= 1'b0;
      wrap_q        <= 1'b0;
      cycle_count_q <= '0;
      err_onehot_q  <= 1'b0;
      err_seq_q     <= 1'b0;
      err_carry_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      step_q        <= step_d;
      wrap_q        <= wrap_d;
      cycle_count_q <= cycle_count_d;
      err_onehot_q  <= err_onehot_d;
      err_seq_q     <= err_seq_d;
      err_carry_q   <= err_carry_d;
    end
  end

  assign index_o       = index_q;
  assign index_valid_o = (state_q == StLock);
  assign step_o        = step_q;
  assign wrap_o        = wrap_q;
  assign cycle_count_o = cycle_count_q;
  assign err_onehot_o  = err_onehot_q;
  assign err_seq_o     = err_seq_q;
  assign err_carry_o   = err_carry_q;

endmodule

// File: tb/tb_octal_decode_monitor.sv
// Directed and random checks of octal_decode_monitor against a behavioural model.
module tb_octal_decode_monitor;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic [7:0]  decoded_i = 8'h00;
  logic        carry_i = 1'b0;
  logic        clear_err_i = 1'b0;
  logic [2:0]  index_o;
  logic        index_valid_o, step_o, wrap_o;
  logic [15:0] cycle_count_o;
  logic        err_onehot_o, err_seq_o, err_carry_o;

  octal_decode_monitor dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .enable_i      (enable_i),
    .decoded_i     (decoded_i),
    .carry_i       (carry_i),
    .clear_err_i   (clear_err_i),
    .index_o       (index_o),
    .index_valid_o (index_valid_o),
    .step_o        (step_o),
    .wrap_o        (wrap_o),
    .cycle_count_o (cycle_count_o),
    .err_onehot_o  (err_onehot_o),
    .err_seq_o     (err_seq_o),
    .err_carry_o   (err_carry_o)
  );

  always #5 clk_i = ~clk_i;

  int n_asserts = 0;
  int n_fail    = 0;
  int step_seen = 0;
  int wrap_seen = 0;

  // Reference model: a held sample, "locked" flag, last index, count and flags.
  bit         m_locked, m_step, m_wrap, m_eoh, m_eseq, m_ecar;
  int         m_idx, m_cnt;
  logic [7:0] s1_dec;
  bit         s1_car, s1_en;
  int         drv_idx;

  function automatic logic [7:0] oh(input int k);
    logic [7:0] v;
    v = 8'h01;
    return v << k;
  endfunction

  function automatic bit car(input int k);
    return (k < 4);
  endfunction

  // Returns the set bit position, or -1 unless exactly one bit is set.
  function automatic int oh_index(input logic [7:0] d);
    int pos;
    pos = -1;
    if ($countones(d) != 1) return -1;
    for (int i = 0; i < 8; i++) if (d[i]) pos = i;
    return pos;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_step = 0; m_wrap = 0;
    m_eoh = 0; m_eseq = 0; m_ecar = 0;
    m_idx = 0; m_cnt = 0;
    s1_dec = 8'h00; s1_car = 0; s1_en = 0;
  endtask

  task automatic model_edge();
    int k;
    bit n_oh, n_seq, n_car;
    n_oh = 0; n_seq = 0; n_car = 0;
    m_step = 0; m_wrap = 0;
    if (s1_en) begin
      k = oh_index(s1_dec);
      if (k < 0) begin
        n_oh = 1;
        m_locked = 0;
      end else begin
        n_car = (s1_car != car(k));
        if (!m_locked) begin
          m_locked = 1;
          m_idx = k;
        end else if (k == (m_idx + 1) % 8) begin
          m_step = 1;
          if (m_idx == 7) begin
            m_wrap = 1;
            m_cnt = (m_cnt + 1) % 65536;
          end
          m_idx = k;
        end else if (k != m_idx) begin
          n_seq = 1;
          m_idx = k;
        end
      end
    end
    if (clear_err_i) begin
      m_eoh = 0; m_eseq = 0; m_ecar = 0;
    end
    m_eoh  = m_eoh  | n_oh;
    m_eseq = m_eseq | n_seq;
    m_ecar = m_ecar | n_car;
    s1_dec = decoded_i; s1_car = carry_i; s1_en = enable_i;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("index", 16'(index_o), 16'(m_idx));
    chk("index_valid", 16'(index_valid_o), 16'(m_locked));
    chk("step", 16'(step_o), 16'(m_step));
    chk("wrap", 16'(wrap_o), 16'(m_wrap));
    chk("cycle_count", cycle_count_o, 16'(m_cnt));
    chk("err_onehot", 16'(err_onehot_o), 16'(m_eoh));
    chk("err_seq", 16'(err_seq_o), 16'(m_eseq));
    chk("err_carry", 16'(err_carry_o), 16'(m_ecar));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check just after it.
  task automatic step(input logic [7:0] d, input bit c, input bit e, input bit clr);
    decoded_i = d; carry_i = c; enable_i = e; clear_err_i = clr;
    @(posedge clk_i);
    model_edge();
    #1;
    check_all();
    step_seen += int'(step_o);
    wrap_seen += int'(wrap_o);
  endtask

  task automatic leg(input int k, input bit e, input bit clr);
    step(oh(k), car(k), e, clr);
  endtask

  initial begin
    int s0, w0, r;
    logic [7:0] d;
    bit c;

    // Reset state.
    model_reset();
    #12;
    check_all();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Legal sequence 0..7,0 then flush.
    s0 = step_seen; w0 = wrap_seen;
    for (int i = 0; i < 9; i++) leg(i % 8, 1, 0);
    leg(0, 1, 0);
    leg(0, 1, 0);
    chk("seq_step_pulses", 16'(step_seen - s0), 16'd8);
    chk("seq_wrap_pulses", 16'(wrap_seen - w0), 16'd1);
    chk("seq_cycle_count", cycle_count_o, 16'd1);

    // Out-of-sequence jump 2 -> 5, then legal 5 -> 6.
    leg(1, 1, 0); leg(2, 1, 0); leg(2, 1, 0);
    leg(5, 1, 0); leg(6, 1, 0);
    chk("jump_err_seq", 16'(err_seq_o), 16'd1);
    chk("jump_index", 16'(index_o), 16'd5);
    leg(6, 1, 0);
    chk("after_jump_step", 16'(step_o), 16'd1);

    // Zero then multi-bit samples, then resync on index 0.
    step(8'h00, 0, 1, 0); step(8'h18, 0, 1, 0); leg(0, 1, 0);
    chk("fault_valid", 16'(index_valid_o), 16'd0);
    leg(0, 1, 0); leg(0, 1, 0);
    chk("resync_index", 16'(index_o), 16'd0);

    // Carry error, clear, then clear coincident with a new carry error.
    leg(0, 1, 1); leg(0, 1, 0);
    step(oh(5), 1'b1, 1, 0); leg(5, 1, 0); leg(5, 1, 0);
    chk("carry_err", 16'(err_carry_o), 16'd1);
    leg(5, 1, 1);
    chk("clear_all", 16'({err_onehot_o, err_seq_o, err_carry_o}), 16'd0);
    step(oh(5), 1'b1, 1, 0); leg(5, 1, 1);
    chk("clear_vs_new", 16'(err_carry_o), 16'd1);
    leg(5, 1, 1); leg(5, 1, 0);

    // Enable low while advancing three counts, then re-enable on the +3 jump.
    leg(6, 0, 0); leg(7, 0, 0); leg(0, 0, 0);
    leg(0, 1, 0); leg(0, 1, 0);
    chk("hold_index", 16'(index_o), 16'd0);
    chk("reenable_err_seq", 16'(err_seq_o), 16'd1);

    // Preload the cycle counter at its top value, then one more 7 -> 0.
    leg(0, 1, 1); leg(6, 1, 0); leg(7, 1, 0); leg(7, 0, 0);
    force dut.cycle_count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    leg(7, 0, 0);
    release dut.cycle_count_q;
    leg(7, 1, 0); leg(0, 1, 0); leg(0, 1, 0);
    chk("count_rollover", cycle_count_o, 16'h0000);

    // Asynchronous reset mid-sequence.
    leg(1, 1, 0); leg(2, 1, 0);
    decoded_i = oh(3); carry_i = 1'b1;
    #3;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("reset_state_acquire", 16'(dut.state_q), 16'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    leg(3, 1, 0); leg(4, 1, 0); leg(4, 1, 0);

    // Random walk, mostly legal advances.
    drv_idx = m_idx;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        drv_idx = (drv_idx + 1) % 8; d = oh(drv_idx);
      end else if (r < 80) begin
        d = oh(drv_idx);
      end else if (r < 88) begin
        drv_idx = $urandom_range(0, 7); d = oh(drv_idx);
      end else if (r < 94) begin
        d = 8'($urandom_range(0, 255));
      end else begin
        d = 8'h00;
      end
      c = car(drv_idx);
      if ($urandom_range(0, 19) == 0) c = ~c;
      step(d, c, ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/octal_decode_monitor.md
OCTAL_DECODE_MONITOR -- requirements
Module: octal_decode_monitor

Interface
REQ-001 The block SHALL expose ports: CLOCK  in  1  sole clock, all state on rising edge.
REQ-002 RESET_N  in  1  asynchronous, active-low reset.
REQ-003 ENABLE  in  1  sample qualifier; low = hold all state.
REQ-004 DECODED_IN  in  8  1-of-8 decoded count from an octal Johnson counter.
REQ-005 CARRY_IN  in  1  counter carry; high for counts 0-3, low for 4-7.
REQ-006 CLEAR_ERR  in  1  synchronous clear of sticky error flags.
REQ-007 INDEX  out  3  binary index of last accepted one-hot sample.
REQ-008 INDEX_VALID  out  1  high while in LOCK state.
REQ-009 STEP  out  1  one-cycle pulse on legal +1 advance.
REQ-010 WRAP  out  1  one-cycle pulse on legal 7->0 advance.
REQ-011 CYCLE_COUNT  out  16  count of legal 7->0 advances.
REQ-012 ERR_ONEHOT, ERR_SEQ, ERR_CARRY  out  1 each  sticky error flags.

Function
REQ-013 Stage 1 SHALL register DECODED_IN, CARRY_IN, ENABLE each cycle; all outputs SHALL be registered from stage 1, giving 2-cycle input-to-output latency.
REQ-014 FSM states: ACQUIRE (reset state), LOCK, FAULT.
REQ-015 A sample is legal one-hot iff exactly one bit of DECODED_IN is set; its index is that bit position.
REQ-016 ACQUIRE or FAULT + legal one-hot -> LOCK, INDEX loaded, no STEP/WRAP; non-one-hot -> stay, ERR_ONEHOT set.
REQ-017 LOCK + same index -> stay, no pulse.
REQ-018 LOCK + index = (INDEX+1) mod 8 -> STEP=1, INDEX updated; if INDEX was 7, WRAP=1 and CYCLE_COUNT+1.
REQ-019 LOCK + any other legal index -> ERR_SEQ set, INDEX reloaded, stay LOCK, no pulses.
REQ-020 LOCK + non-one-hot (zero or multiple bits) -> FAULT, INDEX_VALID=0, INDEX held, ERR_ONEHOT set.
REQ-021 For every legal one-hot sample, CARRY_IN not equal to (index<4) SHALL set ERR_CARRY; index/FSM update proceeds regardless.
REQ-022 Stage-1 ENABLE low: no evaluation; FSM, INDEX, CYCLE_COUNT, flags hold; STEP/WRAP=0.
REQ-023 CYCLE_COUNT SHALL wrap 0xFFFF->0x0000 with no flag.
REQ-024 CLEAR_ERR clears all three flags next edge; a new error detected in the same cycle wins (flag stays/becomes 1).
REQ-025 STEP and WRAP SHALL never be high for more than one consecutive cycle per advance.

Reset
REQ-026 RESET_N low SHALL immediately force: FSM=ACQUIRE, stage-1 registers=0, INDEX=0, INDEX_VALID=0, STEP=0, WRAP=0, CYCLE_COUNT=0, all error flags=0.
REQ-027 Reset asserted mid-operation SHALL discard any in-flight sample; first evaluation after release uses the first post-release stage-1 sample.

Structure
REQ-028 Shared package octal_mon_pkg SHALL hold FSM state encodings, DECODED width (8), INDEX width (3), CYCLE_COUNT width (16), carry threshold (4).
REQ-029 One combinational sub-module onehot_encoder (8-bit in -> 3-bit index + legal flag) SHALL be instantiated.

Verification
REQ-030 Reset, ENABLE=1, drive legal sequence 0..7,0 one per cycle with correct carry -> INDEX tracks at 2-cycle latency, 8 STEP pulses, 1 WRAP, CYCLE_COUNT=1, no flags.
REQ-031 From LOCK at index 2, drive 0x20 (index 5) -> ERR_SEQ=1, INDEX=5, no STEP; then 0x40 -> STEP, no new error.
REQ-032 In LOCK drive 0x00, then 0x18 -> FAULT, INDEX_VALID=0, ERR_ONEHOT=1; then 0x01 -> LOCK, INDEX=0, no STEP.
REQ-033 Index 5 (0x20) with CARRY_IN=1 -> ERR_CARRY=1; pulse CLEAR_ERR with legal input -> all flags 0; pulse CLEAR_ERR coincident with carry error -> ERR_CARRY stays 1.
REQ-034 ENABLE=0 while DECODED_IN advances 3 steps -> no STEP, INDEX held; ENABLE=1 on a +3 jump -> ERR_SEQ=1.
REQ-035 Preload 65535 wraps then one more 7->0 -> CYCLE_COUNT=0x0000; assert RESET_N low mid-sequence -> all outputs 0 asynchronously, FSM=ACQUIRE.
